// File: rtl/toysram_pkg.sv
// Shared types and constants for the 2R1W register-file macro.
package toysram_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } rf_state_e;

  localparam int unsigned INIT_VAL_DEFAULT = 0;

  // Address width for a given depth; never narrower than one bit.
  function automatic int calc_aw(input int words);
    return (words <= 2) ? 1 : $clog2(words);
  endfunction

endpackage

// File: rtl/toysram_rf_rdport.sv
// One registered read port: range check, word select, write bypass, output register.
module toysram_rf_rdport
  import toysram_pkg::*;
#(
  parameter int WORDS  = 16,
  parameter int BITS   = 12,
  parameter bit BYPASS = 1'b1,
  localparam int AW    = calc_aw(WORDS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run_i,
  input  logic            en_i,
  input  logic [AW-1:0]   addr_i,
  input  logic [BITS-1:0] mem_i [WORDS],
  input  logic            wr_ok_i,
  input  logic [AW-1:0]   wr_addr_i,
  input  logic [BITS-1:0] wr_data_i,
  output logic [BITS-1:0] data_o,
  output logic            oob_o
);

  // Compare one bit wider than the address so WORDS = 2**AW still fits.
  localparam logic [AW:0] WORDS_EXT = (AW+1)'(WORDS);

  logic            oob;
  logic [BITS-1:0] word_sel;
  logic [BITS-1:0] data_d;
  logic [BITS-1:0] data_q;

  assign oob   = ({1'b0, addr_i} >= WORDS_EXT);
  assign oob_o = en_i && oob;

  // Word select by explicit compare so out-of-range addresses never index the array.
  always_comb begin
    word_sel = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (addr_i == AW'(i)) word_sel = mem_i[i];
    end
  end

  // Next read value: zero when out of range, optionally the in-flight write data.
  always_comb begin
    data_d = word_sel;
    if (oob) begin
      data_d = '0;
    end else if (BYPASS && wr_ok_i && (wr_addr_i == addr_i)) begin
      data_d = wr_data_i;
    end
  end

  // Output register only loads on an enabled read while the array is live.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else if (run_i && en_i) begin
      data_q <= data_d;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/toysram_rf_2r1w.sv
// 2-read/1-write flop register file with post-reset hardware clear and sticky error flags.
module toysram_rf_2r1w
  import toysram_pkg::*;
#(
  parameter int WORDS                = 16,
  parameter int BITS                 = 12,
  parameter bit BYPASS               = 1'b1,
  parameter logic [BITS-1:0] INIT_VAL = BITS'(INIT_VAL_DEFAULT),
  localparam int AW                  = calc_aw(WORDS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            rd0_en,
  input  logic [AW-1:0]   rd0_addr,
  output logic [BITS-1:0] rd0_data,
  input  logic            rd1_en,
  input  logic [AW-1:0]   rd1_addr,
  output logic [BITS-1:0] rd1_data,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [BITS-1:0] wr_data,
  output logic            ready,
  output logic            err_addr,
  output logic            err_busy,
  input  logic            err_clr
);

  // state   | meaning
  // ST_INIT | clear sequence writing INIT_VAL to word[cnt], ports refused
  // ST_RUN  | normal operation, terminal until reset

  localparam logic [AW:0]   WORDS_EXT = (AW+1)'(WORDS);
  localparam logic [AW-1:0] CNT_LAST  = AW'(WORDS - 1);

  rf_state_e       state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic [BITS-1:0] mem_q [WORDS];

  logic            run;
  logic            wr_oob;
  logic            wr_ok;
  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [BITS-1:0] mem_wdata;
  logic            rd0_oob, rd1_oob;
  logic            addr_set, busy_set;
  logic            err_addr_q, err_addr_d;
  logic            err_busy_q, err_busy_d;

  assign run    = (state_q == ST_RUN);
  assign wr_oob = ({1'b0, wr_addr} >= WORDS_EXT);
  assign wr_ok  = run && wr_en && !wr_oob;

  // Clear sequence walks the counter once, then parks in RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase
  end

  // FSM and clear-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Single array write port shared by the clear sequence and the user port.
  always_comb begin
    mem_we    = wr_ok;
    mem_waddr = wr_addr;
    mem_wdata = wr_data;
    if (!run) begin
      mem_we    = 1'b1;
      mem_waddr = cnt_q;
      mem_wdata = INIT_VAL;
    end
  end

  // Array storage; contents are established by the clear sequence, not by reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < WORDS; i++) begin
      if (mem_we && (mem_waddr == AW'(i))) mem_q[i] <= mem_wdata;
    end
  end

  toysram_rf_rdport #(
    .WORDS  (WORDS),
    .BITS   (BITS),
    .BYPASS (BYPASS)
  ) u_rd0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .run_i     (run),
    .en_i      (rd0_en),
    .addr_i    (rd0_addr),
    .mem_i     (mem_q),
    .wr_ok_i   (wr_ok),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .data_o    (rd0_data),
    .oob_o     (rd0_oob)
  );

  toysram_rf_rdport #(
    .WORDS  (WORDS),
    .BITS   (BITS),
    .BYPASS (BYPASS)
  ) u_rd1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .run_i     (run),
    .en_i      (rd1_en),
    .addr_i    (rd1_addr),
    .mem_i     (mem_q),
    .wr_ok_i   (wr_ok),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .data_o    (rd1_data),
    .oob_o     (rd1_oob)
  );

  assign addr_set = rd0_oob || rd1_oob || (wr_en && wr_oob);
  assign busy_set = !run && (rd0_en || rd1_en || wr_en);

  // Sticky flags: a set in the same cycle as err_clr wins.
  always_comb begin
    err_addr_d = addr_set || (err_addr_q && !err_clr);
    err_busy_d = busy_set || (err_busy_q && !err_clr);
  end

  // Error flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_addr_q <= 1'b0;
      err_busy_q <= 1'b0;
    end else begin
      err_addr_q <= err_addr_d;
      err_busy_q <= err_busy_d;
    end
  end

  assign ready    = run;
  assign err_addr = err_addr_q;
  assign err_busy = err_busy_q;

endmodule

// File: tb/tb_toysram_rf_2r1w.sv
// Bench: two macro configurations driven in lockstep against a behavioural scoreboard.
//   A: WORDS=16, BYPASS=1, INIT_VAL=0x000
//   B: WORDS=12, BYPASS=0, INIT_VAL=0x0F0
module tb_toysram_rf_2r1w;

  typedef struct packed {
    logic [11:0] rd0;
    logic [11:0] rd1;
    logic        rdy;
    logic        ea;
    logic        eb;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rd0_en = 1'b0, rd1_en = 1'b0, wr_en = 1'b0, err_clr = 1'b0;
  logic [3:0]  rd0_addr = '0, rd1_addr = '0, wr_addr = '0;
  logic [11:0] wr_data = '0;

  logic [11:0] rd0_a, rd1_a, rd0_b, rd1_b;
  logic        rdy_a, ea_a, eb_a, rdy_b, ea_b, eb_b;

  int n_vec = 0;
  int n_bad = 0;

  exp_t exp_a[$];
  exp_t exp_b[$];
  exp_t ea, eb;

  logic [11:0] m_mem [2][16];
  int          m_cnt [2];
  logic        m_run [2];
  logic [11:0] m_rd0 [2];
  logic [11:0] m_rd1 [2];
  logic        m_ea  [2];
  logic        m_eb  [2];

  always #5 clk = ~clk;

  toysram_rf_2r1w #(.WORDS(16), .BITS(12), .BYPASS(1'b1), .INIT_VAL(12'h000)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .rd0_en(rd0_en), .rd0_addr(rd0_addr), .rd0_data(rd0_a),
    .rd1_en(rd1_en), .rd1_addr(rd1_addr), .rd1_data(rd1_a),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .ready(rdy_a), .err_addr(ea_a), .err_busy(eb_a), .err_clr(err_clr)
  );

  toysram_rf_2r1w #(.WORDS(12), .BITS(12), .BYPASS(1'b0), .INIT_VAL(12'h0F0)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .rd0_en(rd0_en), .rd0_addr(rd0_addr), .rd0_data(rd0_b),
    .rd1_en(rd1_en), .rd1_addr(rd1_addr), .rd1_data(rd1_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .ready(rdy_b), .err_addr(ea_b), .err_busy(eb_b), .err_clr(err_clr)
  );

  function automatic int cfg_words(input int c);
    return (c == 0) ? 16 : 12;
  endfunction

  function automatic logic cfg_bypass(input int c);
    return (c == 0);
  endfunction

  function automatic logic [11:0] cfg_init(input int c);
    return (c == 0) ? 12'h000 : 12'h0F0;
  endfunction

  function automatic logic [11:0] model_read(input int c, input logic [3:0] a, input logic we,
                                              input logic [3:0] wa, input logic [11:0] wd);
    if (int'(a) >= cfg_words(c)) return 12'h000;
    if (cfg_bypass(c) && we && (int'(wa) < cfg_words(c)) && (wa == a)) return wd;
    return m_mem[c][a];
  endfunction

  // Reset both macros and the model; reset stays asserted until release_reset.
  task automatic apply_reset();
    rst_n = 1'b0;
    {rd0_en, rd1_en, wr_en, err_clr} = '0;
    rd0_addr = '0; rd1_addr = '0; wr_addr = '0; wr_data = '0;
    for (int c = 0; c < 2; c++) begin
      m_cnt[c] = 0; m_run[c] = 1'b0; m_rd0[c] = '0; m_rd1[c] = '0;
      m_ea[c] = 1'b0; m_eb[c] = 1'b0;
    end
    exp_a.delete();
    exp_b.delete();
    #2;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Apply one cycle of stimulus, push the model's post-edge expectation, step past the edge.
  task automatic drive_cycle(input logic r0e, input logic [3:0] r0a,
                             input logic r1e, input logic [3:0] r1a,
                             input logic we,  input logic [3:0] wa,
                             input logic [11:0] wd, input logic ec);
    rd0_en = r0e; rd0_addr = r0a; rd1_en = r1e; rd1_addr = r1a;
    wr_en = we; wr_addr = wa; wr_data = wd; err_clr = ec;
    for (int c = 0; c < 2; c++) begin
      exp_t e;
      int   w;
      logic a_set, b_set;
      w = cfg_words(c);
      if (m_run[c] && r0e) m_rd0[c] = model_read(c, r0a, we, wa, wd);
      if (m_run[c] && r1e) m_rd1[c] = model_read(c, r1a, we, wa, wd);
      a_set = (r0e && int'(r0a) >= w) || (r1e && int'(r1a) >= w) || (we && int'(wa) >= w);
      b_set = !m_run[c] && (r0e || r1e || we);
      m_ea[c] = a_set || (m_ea[c] && !ec);
      m_eb[c] = b_set || (m_eb[c] && !ec);
      if (!m_run[c]) begin
        m_mem[c][m_cnt[c]] = cfg_init(c);
        if (m_cnt[c] == w - 1) m_run[c] = 1'b1;
        else m_cnt[c]++;
      end else if (we && int'(wa) < w) begin
        m_mem[c][wa] = wd;
      end
      e = '{rd0: m_rd0[c], rd1: m_rd1[c], rdy: m_run[c], ea: m_ea[c], eb: m_eb[c]};
      if (c == 0) exp_a.push_back(e);
      else exp_b.push_back(e);
    end
    @(posedge clk);
    #1;
    ea = exp_a.pop_front();
    eb = exp_b.pop_front();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(0, 0, 0, 0, 0, 0, 12'h000, 0);
  endtask

  task automatic test_reset();
    apply_reset();
    n_vec++;
    if ({rd0_a, rd1_a, rdy_a, ea_a, eb_a} !== '0) begin
      n_bad++; $display("FAIL reset_a: got %h expected 0", {rd0_a, rd1_a, rdy_a, ea_a, eb_a});
    end
    n_vec++;
    if ({rd0_b, rd1_b, rdy_b, ea_b, eb_b} !== '0) begin
      n_bad++; $display("FAIL reset_b: got %h expected 0", {rd0_b, rd1_b, rdy_b, ea_b, eb_b});
    end
    release_reset();
    for (int k = 0; k < 17; k++) begin
      drive_cycle(1, 4'd3, 0, 0, 0, 0, 12'h000, 0);
      n_vec++;
      if (rdy_a !== ea.rdy || rd0_a !== ea.rd0) begin
        n_bad++; $display("FAIL init_a[%0d]: got rdy=%b rd0=%h expected rdy=%b rd0=%h", k, rdy_a, rd0_a, ea.rdy, ea.rd0);
      end
      n_vec++;
      if (rdy_b !== eb.rdy || rd0_b !== eb.rd0) begin
        n_bad++; $display("FAIL init_b[%0d]: got rdy=%b rd0=%h expected rdy=%b rd0=%h", k, rdy_b, rd0_b, eb.rdy, eb.rd0);
      end
      if (k == 14) begin
        n_vec++;
        if (rdy_a !== 1'b0) begin n_bad++; $display("FAIL ready_early_a: got %b expected 0", rdy_a); end
      end
      if (k == 15) begin
        n_vec++;
        if (rdy_a !== 1'b1) begin n_bad++; $display("FAIL ready_edge16_a: got %b expected 1", rdy_a); end
      end
    end
    n_vec++;
    if (eb_a !== 1'b1 || eb_b !== 1'b1) begin
      n_bad++; $display("FAIL busy_set: got a=%b b=%b expected 1 1", eb_a, eb_b);
    end
    n_vec++;
    if (rd0_b !== 12'h0F0) begin n_bad++; $display("FAIL init_val_b: got %h expected 0f0", rd0_b); end
  endtask

  task automatic test_write_read();
    drive_cycle(0, 0, 0, 0, 1, 4'd5, 12'hA5C, 1);
    drive_cycle(1, 4'd5, 1, 4'd5, 0, 0, 12'h000, 0);
    n_vec++;
    if (rd0_a !== ea.rd0 || rd1_a !== ea.rd1 || rd0_a !== 12'hA5C) begin
      n_bad++; $display("FAIL wr_rd_a: got %h/%h expected %h/%h", rd0_a, rd1_a, ea.rd0, ea.rd1);
    end
    n_vec++;
    if (rd0_b !== eb.rd0 || rd1_b !== eb.rd1 || rd1_b !== 12'hA5C) begin
      n_bad++; $display("FAIL wr_rd_b: got %h/%h expected %h/%h", rd0_b, rd1_b, eb.rd0, eb.rd1);
    end
    n_vec++;
    if (eb_a !== 1'b0 || eb_b !== 1'b0) begin
      n_bad++; $display("FAIL busy_clr: got a=%b b=%b expected 0 0", eb_a, eb_b);
    end
    idle(1);
    n_vec++;
    if (rd0_a !== 12'hA5C) begin n_bad++; $display("FAIL rd_hold_a: got %h expected a5c", rd0_a); end
  endtask

  task automatic test_bypass();
    drive_cycle(0, 0, 0, 0, 1, 4'd7, 12'h123, 0);
    drive_cycle(1, 4'd7, 1, 4'd7, 1, 4'd7, 12'h456, 0);
    n_vec++;
    if (rd0_a !== 12'h456 || rd1_a !== ea.rd1) begin
      n_bad++; $display("FAIL bypass_a: got %h/%h expected 456/%h", rd0_a, rd1_a, ea.rd1);
    end
    n_vec++;
    if (rd0_b !== 12'h123 || rd1_b !== eb.rd1) begin
      n_bad++; $display("FAIL bypass_b: got %h/%h expected 123/%h", rd0_b, rd1_b, eb.rd1);
    end
    drive_cycle(1, 4'd7, 0, 0, 0, 0, 12'h000, 0);
    n_vec++;
    if (rd0_b !== 12'h456) begin n_bad++; $display("FAIL after_write_b: got %h expected 456", rd0_b); end
  endtask

  task automatic test_oob();
    drive_cycle(0, 0, 0, 0, 1, 4'd1, 12'h111, 0);
    drive_cycle(0, 0, 0, 0, 1, 4'd13, 12'hFFF, 0);
    n_vec++;
    if (ea_b !== 1'b1 || ea_a !== 1'b0) begin
      n_bad++; $display("FAIL wr_oob_flag: got a=%b b=%b expected 0 1", ea_a, ea_b);
    end
    drive_cycle(1, 4'd13, 1, 4'd1, 0, 0, 12'h000, 0);
    n_vec++;
    if (rd0_b !== 12'h000 || rd1_b !== 12'h111 || ea_b !== eb.ea) begin
      n_bad++; $display("FAIL rd_oob_b: got %h/%h ea=%b expected 000/111 ea=%b", rd0_b, rd1_b, ea_b, eb.ea);
    end
    n_vec++;
    if (rd0_a !== 12'hFFF || rd1_a !== ea.rd1) begin
      n_bad++; $display("FAIL rd13_a: got %h/%h expected fff/%h", rd0_a, rd1_a, ea.rd1);
    end
    for (int i = 0; i < 12; i++) begin
      drive_cycle(1, 4'(i), 0, 0, 0, 0, 12'h000, 0);
      n_vec++;
      if (rd0_b !== eb.rd0) begin n_bad++; $display("FAIL scan_b[%0d]: got %h expected %h", i, rd0_b, eb.rd0); end
    end
  endtask

  task automatic test_err_clr();
    drive_cycle(0, 0, 0, 0, 0, 0, 12'h000, 1);
    n_vec++;
    if (ea_b !== 1'b0) begin n_bad++; $display("FAIL clr_alone_b: got %b expected 0", ea_b); end
    drive_cycle(0, 0, 1, 4'd14, 0, 0, 12'h000, 0);
    drive_cycle(0, 0, 1, 4'd12, 0, 0, 12'h000, 1);
    n_vec++;
    if (ea_b !== 1'b1) begin n_bad++; $display("FAIL set_dominant_b: got %b expected 1", ea_b); end
    n_vec++;
    if (ea_a !== ea.ea || rd1_a !== ea.rd1) begin
      n_bad++; $display("FAIL clr_a: got ea=%b rd1=%h expected ea=%b rd1=%h", ea_a, rd1_a, ea.ea, ea.rd1);
    end
    drive_cycle(0, 0, 0, 0, 0, 0, 12'h000, 1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 60; i++) begin
      drive_cycle(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                  12'($urandom), ($urandom_range(0, 7) == 0));
      n_vec++;
      if ({rd0_a, rd1_a, rdy_a, ea_a, eb_a} !== ea) begin
        n_bad++; $display("FAIL b2b_a[%0d]: got %h expected %h", i, {rd0_a, rd1_a, rdy_a, ea_a, eb_a}, ea);
      end
      n_vec++;
      if ({rd0_b, rd1_b, rdy_b, ea_b, eb_b} !== eb) begin
        n_bad++; $display("FAIL b2b_b[%0d]: got %h expected %h", i, {rd0_b, rd1_b, rdy_b, ea_b, eb_b}, eb);
      end
    end
  endtask

  task automatic test_reset_mid();
    drive_cycle(0, 0, 0, 0, 1, 4'd2, 12'h3C3, 1);
    drive_cycle(1, 4'd2, 0, 0, 0, 0, 12'h000, 0);
    n_vec++;
    if (rd0_a !== 12'h3C3 || rd0_b !== 12'h3C3) begin
      n_bad++; $display("FAIL pre_reset: got a=%h b=%h expected 3c3 3c3", rd0_a, rd0_b);
    end
    apply_reset();
    n_vec++;
    if ({rd0_a, rdy_a, rd0_b, rdy_b} !== '0) begin
      n_bad++; $display("FAIL reset_run: got %h expected 0", {rd0_a, rdy_a, rd0_b, rdy_b});
    end
    release_reset();
    drive_cycle(1, 4'd2, 0, 0, 0, 0, 12'h000, 0);
    idle(3);
    n_vec++;
    if (eb_a !== 1'b1) begin n_bad++; $display("FAIL busy_mid_init: got %b expected 1", eb_a); end
    apply_reset();
    n_vec++;
    if ({rdy_a, eb_a, rdy_b, eb_b} !== '0) begin
      n_bad++; $display("FAIL reset_init: got %b expected 0000", {rdy_a, eb_a, rdy_b, eb_b});
    end
    release_reset();
    for (int k = 0; k < 16; k++) begin
      drive_cycle(0, 0, 0, 0, 0, 0, 12'h000, 0);
      n_vec++;
      if (rdy_a !== ea.rdy || rdy_b !== eb.rdy) begin
        n_bad++; $display("FAIL reinit_rdy[%0d]: got %b/%b expected %b/%b", k, rdy_a, rdy_b, ea.rdy, eb.rdy);
      end
    end
    drive_cycle(1, 4'd2, 1, 4'd2, 0, 0, 12'h000, 0);
    n_vec++;
    if (rd0_a !== 12'h000 || rd1_a !== 12'h000) begin
      n_bad++; $display("FAIL reinit_a: got %h/%h expected 000/000", rd0_a, rd1_a);
    end
    n_vec++;
    if (rd0_b !== 12'h0F0 || rd1_b !== 12'h0F0) begin
      n_bad++; $display("FAIL reinit_b: got %h/%h expected 0f0/0f0", rd0_b, rd1_b);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_oob();
    test_err_clr();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/toysram_rf_2r1w.md
Name: toysram_rf_2r1w

Overview:
Parametrised, clocked successor to the 16x12 behavioural subarray. It is a 2-read/1-write register-file macro with encoded addresses, registered read data and a configurable write-to-read bypass. After reset it runs a hardware clear sequence, and it reports illegal accesses through sticky error flags. It sits between the array-shard address/control logic and the datapath, and replaces raw wordline/bitline drive with a synchronous port interface.

Parameters:
WORDS, 16, number of words; any value from 2 to 256, need not be a power of 2.
BITS, 12, word width in bits.
AW, $clog2(WORDS), address width; derived, not to be overridden.
BYPASS, 1, 1 = a read of the address being written in the same cycle returns the new data; 0 = it returns the old data.
INIT_VAL, 0, BITS-wide value written to every word by the clear sequence.

Ports:
clk  in  1  clock; all state changes on rising edge.
rst_n  in  1  asynchronous, active-low reset.
rd0_en  in  1  read port 0 enable.
rd0_addr  in  AW  read port 0 address.
rd0_data  out  BITS  read port 0 data, registered.
rd1_en  in  1  read port 1 enable.
rd1_addr  in  AW  read port 1 address.
rd1_data  out  BITS  read port 1 data, registered.
wr_en  in  1  write enable.
wr_addr  in  AW  write address.
wr_data  in  BITS  write data.
ready  out  1  high once the clear sequence has finished.
err_addr  out  1  sticky: an enabled access used an address >= WORDS.
err_busy  out  1  sticky: an enabled access arrived while ready=0.
err_clr  in  1  synchronous clear of both sticky error flags.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - FSM goes to INIT and the clear counter goes to 0.
  - ready, err_addr, err_busy, rd0_data and rd1_data all go to 0.
  - Array contents are not reset directly; the INIT sequence sets them.
- FSM states are INIT and RUN.
  - INIT: write INIT_VAL to word[cnt] each cycle and increment cnt.
  - When cnt = WORDS-1 is written, move to RUN next cycle. ready rises on the first RUN cycle, so INIT takes exactly WORDS cycles after reset deasserts.
  - RUN: terminal state; only reset returns the FSM to INIT.
- Accesses during INIT:
  - Port writes are dropped and reads do not update rd*_data.
  - Any of rd0_en, rd1_en or wr_en high sets err_busy.
- Read (RUN, rdN_en=1):
  - Latency 1: rdN_data = word[rdN_addr] on the next edge.
  - If rdN_en=0, rdN_data holds its previous value.
  - If rdN_addr >= WORDS, rdN_data is loaded with 0 and err_addr is set.
- Write (RUN, wr_en=1, wr_addr < WORDS): word[wr_addr] = wr_data at the edge.
  - wr_addr >= WORDS: the write is dropped, no array state changes, and err_addr is set.
- Same-cycle read and write to the same address:
  - BYPASS=1: rdN_data = wr_data.
  - BYPASS=0: rdN_data = the pre-write word.
  - Both read ports may hit the same address, with or without a write; each behaves independently.
- Error flags:
  - err_addr and err_busy are set-dominant over err_clr: a set and a clear in the same cycle leave the flag at 1.
  - Otherwise err_clr=1 clears the flag on the next edge.
- Reset asserted mid-INIT or mid-RUN: immediate return to the reset state and the clear sequence restarts from word 0 after deassertion.
- All address compares use the full AW width; no wrap-around. This matters for non-power-of-2 WORDS.
- Array storage is a flop array of WORDS x BITS.

Decomposition:
- Shared package toysram_pkg holds:
  - the FSM state typedef (INIT, RUN);
  - the localparam helper computing AW;
  - the default INIT_VAL constant.
- One sub-module, toysram_rf_rdport (address range check, bypass mux, output register), instantiated twice.
- The FSM, clear counter, array and error logic stay in the top module.

Test Plan (WORDS=16, BITS=12, INIT_VAL=0 unless stated):
1. Release reset; hold rd0_en=1, addr 3 from cycle 0 -> ready rises on cycle 16, err_busy=1, rd0_data stays 0x000 until the first RUN read.
2. Write 0xA5C to addr 5, then read addr 5 on both ports next cycle -> rd0_data=rd1_data=0xA5C one cycle after the read.
3. Write 0x123 to addr 7, then in one cycle write 0x456 to addr 7 while reading addr 7 on port 0 -> BYPASS=1 gives 0x456; BYPASS=0 gives 0x123.
4. WORDS=12: write addr 13 with 0xFFF, read addr 13 -> err_addr=1, rd0_data=0x000, words 0-11 unchanged (1 = 13 mod 12 still holds its old value).
5. Set err_addr, then pulse err_clr alone -> cleared next cycle. Pulse err_clr together with another bad address -> stays 1.
6. Write 0x3C3 to addr 2; assert rst_n=0 during the next INIT, at cycle 4 -> outputs zero immediately. After release, ready rises 16 cycles later and addr 2 reads 0x000 (INIT_VAL=0x0F0 variant reads 0x0F0).
